// File: rtl/external_interrupt_controller_pkg.sv
// Shared encodings for the external interrupt controller: FSM states,
// IO command opcodes and the bit layout of the status word.
package external_interrupt_controller_pkg;

   typedef enum logic [1:0] {
      EIC_IDLE = 2'd0,
      EIC_REQ  = 2'd1,
      EIC_SERV = 2'd2
   } eicState_t;

   localparam logic [3:0] EIC_OP_ACK  = 4'h1;
   localparam logic [3:0] EIC_OP_EOI  = 4'h2;
   localparam logic [3:0] EIC_OP_MASK = 4'h3;
   localparam logic [3:0] EIC_OP_CLRP = 4'h4;

   localparam int OPCODE_LSB     = 28;
   localparam int STAT_STATE_LSB = 30;
   localparam int STAT_ID_LSB    = 16;
   localparam int STAT_MASK_LSB  = 8;
   localparam int STAT_PEND_LSB  = 0;

endpackage

// File: rtl/external_interrupt_controller_source_sync.sv
// One interrupt source: 2-FF synchroniser, edge detector and pending bit.
// A new rising edge beats a simultaneous clear so no event is lost.
module eic_source_sync #(
   parameter logic IS_EDGE = 1'b1
) (
   input  logic clk,
   input  logic rstN,
   input  logic irqRaw,
   input  logic clrPend,
   output logic pending,
   output logic pendNext
);

   logic sync1;
   logic sync2;
   logic prevLvl;
   logic rise;

   assign rise = sync2 & ~prevLvl;

   always_comb begin
      if (IS_EDGE)
         pendNext = rise | (pending & ~clrPend);
      else
         pendNext = sync2;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         prevLvl <= 1'b0;
         pending <= 1'b0;
      end else begin
         sync1   <= irqRaw;
         sync2   <= sync1;
         prevLvl <= sync2;
         pending <= pendNext;
      end
   end

endmodule

// File: rtl/external_interrupt_controller.sv
// Fixed-priority external interrupt controller: latches source requests,
// presents the lowest-index eligible one to the core and obeys IO commands.
module external_interrupt_controller
   import external_interrupt_controller_pkg::*;
#(
   parameter int                 NUM_SRC   = 2,
   parameter int                 ID_W      = 1,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = 2'b11,
   parameter logic [NUM_SRC-1:0] MASK_RST  = 2'b11
) (
   input  logic               Sys_Clock,
   input  logic               Sys_Reset,
   input  logic [NUM_SRC-1:0] Irq_Src,
   input  logic               IO_EnR,
   input  logic               IO_EnW,
   input  logic [31:0]        IO_DataW,
   output logic [31:0]        IO_DataR,
   output logic               EIC_I_Req,
   output logic [ID_W-1:0]    EIC_I_Id
);

   eicState_t          state;
   logic               reqReg;
   logic [ID_W-1:0]    idReg;
   logic [31:0]        dataRReg;
   logic [NUM_SRC-1:0] maskReg;
   logic [NUM_SRC-1:0] maskNext;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pendNext;
   logic [NUM_SRC-1:0] clrVec;
   logic [NUM_SRC-1:0] eligible;
   logic [ID_W-1:0]    winner;
   logic [31:0]        statusWord;
   logic [3:0]         opcode;
   logic               cmdAck;
   logic               cmdEoi;
   logic               cmdMask;
   logic               cmdClrp;
   logic               unusedDataBits;

   assign opcode  = IO_DataW[OPCODE_LSB +: 4];
   assign cmdAck  = IO_EnW && (opcode == EIC_OP_ACK) && (state == EIC_REQ);
   assign cmdEoi  = IO_EnW && (opcode == EIC_OP_EOI) && (state == EIC_SERV);
   assign cmdMask = IO_EnW && (opcode == EIC_OP_MASK);
   assign cmdClrp = IO_EnW && (opcode == EIC_OP_CLRP);
   assign unusedDataBits = ^IO_DataW[OPCODE_LSB-1:NUM_SRC];

   assign maskNext = cmdMask ? IO_DataW[NUM_SRC-1:0] : maskReg;
   assign eligible = pending & maskReg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
         // Level sources track their line, so only edge sources take clears.
         assign clrVec[gi] = EDGE_MASK[gi] &&
                             ((cmdClrp && IO_DataW[gi]) ||
                              (cmdEoi && (idReg == ID_W'(gi))));

         eic_source_sync #(
            .IS_EDGE (EDGE_MASK[gi])
         ) uSrc (
            .clk      (Sys_Clock),
            .rstN     (Sys_Reset),
            .irqRaw   (Irq_Src[gi]),
            .clrPend  (clrVec[gi]),
            .pending  (pending[gi]),
            .pendNext (pendNext[gi])
         );
      end
   endgenerate

   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i])
            winner = ID_W'(i);
      end
   end

   always_comb begin
      statusWord = '0;
      statusWord[STAT_STATE_LSB +: 2]      = state;
      statusWord[STAT_ID_LSB +: ID_W]      = idReg;
      statusWord[STAT_MASK_LSB +: NUM_SRC] = maskReg;
      statusWord[STAT_PEND_LSB +: NUM_SRC] = pending;
   end

   always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
      if (!Sys_Reset) begin
         state    <= EIC_IDLE;
         reqReg   <= 1'b0;
         idReg    <= '0;
         dataRReg <= '0;
         maskReg  <= MASK_RST;
      end else begin
         if (IO_EnR)
            dataRReg <= statusWord;
         if (cmdMask)
            maskReg <= IO_DataW[NUM_SRC-1:0];

         case (state)
            EIC_IDLE: begin
               if (|eligible) begin
                  state  <= EIC_REQ;
                  idReg  <= winner;
                  reqReg <= 1'b1;
               end
            end
            EIC_REQ: begin
               // Withdraw at the same edge the request stops being valid.
               if (!maskNext[idReg] || !pendNext[idReg]) begin
                  state  <= EIC_IDLE;
                  reqReg <= 1'b0;
               end else if (cmdAck) begin
                  state  <= EIC_SERV;
                  reqReg <= 1'b0;
               end
            end
            EIC_SERV: begin
               if (cmdEoi)
                  state <= EIC_IDLE;
            end
            default: begin
               state  <= EIC_IDLE;
               reqReg <= 1'b0;
            end
         endcase
      end
   end

   assign IO_DataR  = dataRReg;
   assign EIC_I_Req = reqReg;
   assign EIC_I_Id  = idReg;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Directed bench for external_interrupt_controller: a per-cycle vector table
// plus hand sequences for set-wins-over-EOI and asynchronous reset.
module tb_external_interrupt_controller;

   logic        Sys_Clock = 1'b0;
   logic        Sys_Reset;
   logic [1:0]  Irq_Src;
   logic        IO_EnR;
   logic        IO_EnW;
   logic [31:0] IO_DataW;
   logic [31:0] IO_DataR;
   logic        EIC_I_Req;
   logic [0:0]  EIC_I_Id;

   external_interrupt_controller #(
      .NUM_SRC   (2),
      .ID_W      (1),
      .EDGE_MASK (2'b11),
      .MASK_RST  (2'b11)
   ) dut (
      .Sys_Clock (Sys_Clock),
      .Sys_Reset (Sys_Reset),
      .Irq_Src   (Irq_Src),
      .IO_EnR    (IO_EnR),
      .IO_EnW    (IO_EnW),
      .IO_DataW  (IO_DataW),
      .IO_DataR  (IO_DataR),
      .EIC_I_Req (EIC_I_Req),
      .EIC_I_Id  (EIC_I_Id)
   );

   always #5 Sys_Clock = ~Sys_Clock;

   localparam logic [31:0] ACK  = 32'h1000_0000;
   localparam logic [31:0] EOI  = 32'h2000_0000;

   typedef struct packed {
      logic [1:0]  irq;
      logic        enW;
      logic        enR;
      logic [31:0] dataW;
      logic        expReq;
      logic        expId;
      logic        chkData;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic addVec(input logic [1:0] irq, input logic enW, input logic enR,
                         input logic [31:0] dataW, input logic expReq, input logic expId,
                         input logic chkData, input logic [31:0] expData);
      vec_t v;
      v.irq = irq; v.enW = enW; v.enR = enR; v.dataW = dataW;
      v.expReq = expReq; v.expId = expId; v.chkData = chkData; v.expData = expData;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
      end
   endtask

   // Drive one cycle of inputs at a negedge, return at the following negedge.
   task automatic cycle(input logic [1:0] irq, input logic enW, input logic enR,
                        input logic [31:0] dataW);
      Irq_Src  = irq;
      IO_EnW   = enW;
      IO_EnR   = enR;
      IO_DataW = dataW;
      @(negedge Sys_Clock);
   endtask

   initial begin
      Sys_Reset = 1'b0;
      Irq_Src   = '0;
      IO_EnR    = 1'b0;
      IO_EnW    = 1'b0;
      IO_DataW  = '0;

      //     irq    W  R  dataW          req id chk data
      addVec(2'b10, 0, 0, 32'h0,         0, 0, 0, 32'h0);          // 0 pulse src1
      addVec(2'b10, 0, 0, 32'h0,         0, 0, 0, 32'h0);
      addVec(2'b00, 0, 0, 32'h0,         0, 0, 0, 32'h0);          // pending set
      addVec(2'b00, 0, 0, 32'h0,         1, 1, 0, 32'h0);          // request src1
      addVec(2'b00, 0, 1, 32'h0,         1, 1, 1, 32'h4001_0302);
      addVec(2'b00, 1, 0, ACK,           0, 1, 0, 32'h0);          // 5
      addVec(2'b00, 1, 0, EOI,           0, 1, 0, 32'h0);
      addVec(2'b00, 0, 1, 32'h0,         0, 1, 1, 32'h0001_0300);
      addVec(2'b11, 0, 0, 32'h0,         0, 1, 0, 32'h0);          // both sources
      addVec(2'b11, 0, 0, 32'h0,         0, 1, 0, 32'h0);
      addVec(2'b00, 0, 0, 32'h0,         0, 1, 0, 32'h0);          // 10
      addVec(2'b00, 0, 0, 32'h0,         1, 0, 0, 32'h0);          // src0 wins
      addVec(2'b00, 1, 0, ACK,           0, 0, 0, 32'h0);
      addVec(2'b00, 1, 0, EOI,           0, 0, 0, 32'h0);
      addVec(2'b00, 0, 0, 32'h0,         1, 1, 0, 32'h0);          // re-arm src1
      addVec(2'b00, 1, 1, ACK,           0, 1, 1, 32'h4001_0302);  // 15 read pre-write
      addVec(2'b00, 1, 0, EOI,           0, 1, 0, 32'h0);
      addVec(2'b00, 1, 0, 32'h3000_0001, 0, 1, 0, 32'h0);          // mask src0 only
      addVec(2'b10, 0, 0, 32'h0,         0, 1, 0, 32'h0);
      addVec(2'b10, 0, 0, 32'h0,         0, 1, 0, 32'h0);
      addVec(2'b00, 0, 0, 32'h0,         0, 1, 0, 32'h0);          // 20
      addVec(2'b00, 0, 0, 32'h0,         0, 1, 0, 32'h0);          // masked: no req
      addVec(2'b00, 0, 1, 32'h0,         0, 1, 1, 32'h0001_0102);
      addVec(2'b00, 1, 0, 32'h3000_0003, 0, 1, 0, 32'h0);          // unmask
      addVec(2'b00, 0, 0, 32'h0,         1, 1, 0, 32'h0);
      addVec(2'b00, 1, 0, ACK,           0, 1, 0, 32'h0);          // 25
      addVec(2'b00, 1, 0, EOI,           0, 1, 0, 32'h0);
      addVec(2'b01, 0, 0, 32'h0,         0, 1, 0, 32'h0);
      addVec(2'b01, 0, 0, 32'h0,         0, 1, 0, 32'h0);
      addVec(2'b00, 0, 0, 32'h0,         0, 1, 0, 32'h0);
      addVec(2'b00, 0, 0, 32'h0,         1, 0, 0, 32'h0);          // 30 request src0
      addVec(2'b00, 1, 0, 32'h4000_0001, 0, 0, 0, 32'h0);          // clr -> withdraw
      addVec(2'b00, 1, 0, ACK,           0, 0, 0, 32'h0);          // ignored in IDLE
      addVec(2'b00, 1, 1, EOI,           0, 0, 1, 32'h0000_0300);  // ignored in IDLE

      @(negedge Sys_Clock);
      @(negedge Sys_Clock);
      check("rst_req",  0, 32'(EIC_I_Req), 32'h0);
      check("rst_id",   0, 32'(EIC_I_Id),  32'h0);
      check("rst_data", 0, IO_DataR,       32'h0);
      Sys_Reset = 1'b1;
      @(negedge Sys_Clock);

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].irq, vecs[i].enW, vecs[i].enR, vecs[i].dataW);
         check("vec_req", i, 32'(EIC_I_Req), 32'(vecs[i].expReq));
         check("vec_id",  i, 32'(EIC_I_Id),  32'(vecs[i].expId));
         if (vecs[i].chkData)
            check("vec_data", i, IO_DataR, vecs[i].expData);
         $display("vec %0d: req=%0d id=%0d dataR=%h", i, EIC_I_Req, EIC_I_Id, IO_DataR);
      end

      // New synchronised edge on src0 lands on the same edge as its EOI.
      cycle(2'b01, 0, 0, 32'h0);
      cycle(2'b01, 0, 0, 32'h0);
      cycle(2'b00, 0, 0, 32'h0);
      cycle(2'b00, 0, 0, 32'h0);
      check("t4_req", 0, 32'(EIC_I_Req), 32'h1);
      check("t4_id",  0, 32'(EIC_I_Id),  32'h0);
      cycle(2'b00, 1, 0, ACK);
      check("t4_ack", 0, 32'(EIC_I_Req), 32'h0);
      cycle(2'b01, 0, 0, 32'h0);
      cycle(2'b01, 0, 0, 32'h0);
      cycle(2'b01, 1, 0, EOI);
      check("t4_eoi", 0, 32'(EIC_I_Req), 32'h0);
      cycle(2'b00, 0, 1, 32'h0);
      check("t4_rearm_req",  0, 32'(EIC_I_Req), 32'h1);
      check("t4_rearm_id",   0, 32'(EIC_I_Id),  32'h0);
      check("t4_rearm_data", 0, IO_DataR,       32'h0000_0301);
      $display("set-wins: req=%0d id=%0d dataR=%h", EIC_I_Req, EIC_I_Id, IO_DataR);

      // Enter SERV with a non-reset mask, then reset asynchronously.
      cycle(2'b00, 1, 0, 32'h3000_0001);
      check("t6_req_kept", 0, 32'(EIC_I_Req), 32'h1);
      cycle(2'b00, 1, 0, ACK);
      check("t6_ack", 0, 32'(EIC_I_Req), 32'h0);
      cycle(2'b00, 0, 1, 32'h0);
      check("t6_serv_data", 0, IO_DataR, 32'h8000_0101);
      #2 Sys_Reset = 1'b0;
      #1;
      check("t6_async_req",  0, 32'(EIC_I_Req), 32'h0);
      check("t6_async_id",   0, 32'(EIC_I_Id),  32'h0);
      check("t6_async_data", 0, IO_DataR,       32'h0);
      @(negedge Sys_Clock);
      Sys_Reset = 1'b1;
      @(negedge Sys_Clock);
      cycle(2'b00, 0, 1, 32'h0);
      check("t6_post_data", 0, IO_DataR,       32'h0000_0300);
      check("t6_post_req",  0, 32'(EIC_I_Req), 32'h0);
      $display("async reset: req=%0d id=%0d dataR=%h", EIC_I_Req, EIC_I_Id, IO_DataR);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
